// File: rtl/led_pkg.sv
// Board-level LED constants shared by the matrix scanner files.
// Polarity is set once here; the drivers derive their on/off levels from it.
package led_pkg;

  localparam logic        LED_ACTIVE_LOW = 1'b1;
  localparam logic        LED_ON         = LED_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic        LED_OFF        = ~LED_ON;

  localparam int unsigned DEFAULT_ROWS   = 8;
  localparam int unsigned DEFAULT_COLS   = 4;

endpackage

// File: rtl/led_scan_timer.sv
// Column scan timebase: slot counter, column index, frame-boundary flag
// and the registered frame_start pulse.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int unsigned COLS      = DEFAULT_COLS,
  parameter int unsigned SLOT_LOG2 = 12,
  localparam int unsigned CW       = $clog2(COLS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [SLOT_LOG2-1:0] slot_o,
  output logic [CW-1:0]        col_o,
  output logic                 frame_end_o,
  output logic                 frame_start_o
);

  logic [SLOT_LOG2-1:0] slot_q, slot_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 frame_start_q, frame_start_d;
  logic                 slot_last;
  logic                 col_last;

  always_comb begin
    slot_last     = &slot_q;
    col_last      = (32'(col_q) == COLS - 1);
    slot_d        = slot_q + 1'b1;
    col_d         = col_q;
    if (slot_last) begin
      col_d = col_last ? '0 : col_q + 1'b1;
    end
    frame_start_d = (col_q == '0) && (slot_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q        <= '0;
      col_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign slot_o        = slot_q;
  assign col_o         = col_q;
  assign frame_end_o   = slot_last && col_last;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED-matrix driver with a double-buffered frame store,
// frame-synchronous buffer swap, global PWM brightness and column blanking.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int unsigned ROWS      = DEFAULT_ROWS,
  parameter int unsigned COLS      = DEFAULT_COLS,
  parameter int unsigned SLOT_LOG2 = 12,
  parameter int unsigned BW        = 3,
  localparam int unsigned CW       = $clog2(COLS)
) (
  input  logic            clk12MHz,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_done,
  input  logic [BW-1:0]   brightness,
  output logic            frame_start,
  output logic [ROWS-1:0] led_row,
  output logic [COLS-1:0] led_col
);

  logic [SLOT_LOG2-1:0] slot;
  logic [CW-1:0]        col;
  logic                 frame_end;

  led_scan_timer #(
    .COLS      (COLS),
    .SLOT_LOG2 (SLOT_LOG2)
  ) u_timer (
    .clk_i         (clk12MHz),
    .rst_i         (reset),
    .slot_o        (slot),
    .col_o         (col),
    .frame_end_o   (frame_end),
    .frame_start_o (frame_start)
  );

  logic [ROWS-1:0] buf_q [2][COLS];
  logic            front_q, front_d;
  logic            swap_pending_q, swap_pending_d;
  logic            swap_fired_q;
  logic            swap_done_q;
  logic [BW-1:0]   bright_q, bright_d;
  logic [ROWS-1:0] led_row_q, led_row_d;
  logic [COLS-1:0] led_col_q, led_col_d;

  logic            wr_ok;
  logic            swap_fire;
  logic            pix_on;
  logic [ROWS-1:0] col_word;
  logic [COLS-1:0] col_onehot;

  always_comb begin
    wr_ok          = wr_en && (32'(wr_col) < COLS);
    swap_fire      = frame_end && (swap_pending_q || swap_req);
    swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q || swap_req);
    front_d        = swap_fire ? ~front_q : front_q;
    bright_d       = frame_end ? brightness : bright_q;

    // Slot 0 of every column stays dark so the previous column's pattern cannot ghost.
    pix_on     = (slot != '0) && (slot[SLOT_LOG2-1 -: BW] < bright_q);
    col_word   = buf_q[front_q][col];
    col_onehot = COLS'(1) << col;

    led_row_d = {ROWS{LED_OFF}};
    if (pix_on) begin
      led_row_d = LED_ACTIVE_LOW ? ~col_word : col_word;
    end
    led_col_d = LED_ACTIVE_LOW ? ~col_onehot : col_onehot;
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          buf_q[b][c] <= '0;
        end
      end
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_fired_q   <= 1'b0;
      swap_done_q    <= 1'b0;
      bright_q       <= '0;
      led_row_q      <= {ROWS{LED_OFF}};
      led_col_q      <= {COLS{LED_OFF}};
    end else begin
      // Back buffer is chosen from the pre-swap front, so a boundary write lands in the buffer about to be shown.
      if (wr_ok) begin
        buf_q[~front_q][wr_col] <= wr_data;
      end
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      swap_fired_q   <= swap_fire;
      swap_done_q    <= swap_fired_q;
      bright_q       <= bright_d;
      led_row_q      <= led_row_d;
      led_col_q      <= led_col_d;
    end
  end

  assign swap_done = swap_done_q;
  assign led_row   = led_row_q;
  assign led_col   = led_col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner at ROWS=8, COLS=4, SLOT_LOG2=4, BW=2 (64-cycle frame).
// k counts clock edges since reset release; outputs seen after edge k reflect internal cycle k-1.
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_col;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_done;
  logic [1:0] brightness;
  logic       frame_start;
  logic [7:0] led_row;
  logic [3:0] led_col;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned k      = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .ROWS      (8),
    .COLS      (4),
    .SLOT_LOG2 (4),
    .BW        (2)
  ) dut (
    .clk12MHz    (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .brightness  (brightness),
    .frame_start (frame_start),
    .led_row     (led_row),
    .led_col     (led_col)
  );

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic goto(input int unsigned t);
    if (t < k) begin
      checks++;
      errors++;
      $error("FAIL goto: observed k=%0d required k<=%0d", k, t);
    end
    while (k < t) step(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic write_col(input logic [1:0] c, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_col  = c;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_col     = '0;
    wr_data    = '0;
    swap_req   = 1'b0;
    brightness = '0;

    // 1: reset state and first frame_start
    step(3);
    chk("rst_led_col", 32'(led_col), 32'hF);
    chk("rst_led_row", 32'(led_row), 32'hFF);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_swap_done", 32'(swap_done), 32'h0);
    reset = 1'b0;
    k     = 0;
    step(1);
    chk("fs_first", 32'(frame_start), 32'h1);
    chk("col0_first", 32'(led_col), 32'hE);
    chk("no_swap_first", 32'(swap_done), 32'h0);
    chk("row_dark_bright0", 32'(led_row), 32'hFF);

    // 2: fill back buffer, request swap, brightness 3
    step(1);
    chk("fs_one_cycle", 32'(frame_start), 32'h0);
    write_col(2'd0, 8'hA5);
    write_col(2'd1, 8'h3C);
    write_col(2'd2, 8'hFF);
    write_col(2'd3, 8'h01);
    swap_req   = 1'b1;
    brightness = 2'd3;
    step(1);
    swap_req   = 1'b0;
    goto(16);
    chk("col0_last_slot", 32'(led_col), 32'hE);
    step(1);
    chk("col1_first_slot", 32'(led_col), 32'hD);
    goto(64);
    chk("no_swap_before_boundary", 32'(swap_done), 32'h0);
    chk("no_fs_before_boundary", 32'(frame_start), 32'h0);
    step(1);
    chk("swap_done_f1", 32'(swap_done), 32'h1);
    chk("fs_f1", 32'(frame_start), 32'h1);
    chk("blank_slot0", 32'(led_row), 32'hFF);
    step(1);
    chk("swap_done_one_cycle", 32'(swap_done), 32'h0);
    chk("col0_slot1", 32'(led_row), 32'h5A);
    goto(76);
    chk("col0_slot11", 32'(led_row), 32'h5A);
    step(1);
    chk("col0_slot12", 32'(led_row), 32'hFF);
    goto(80);
    chk("col0_slot15", 32'(led_row), 32'hFF);
    goto(86);
    chk("col1_row", 32'(led_row), 32'hC3);
    chk("col1_strobe", 32'(led_col), 32'hD);
    goto(102);
    chk("col2_row", 32'(led_row), 32'h00);
    chk("col2_strobe", 32'(led_col), 32'hB);
    goto(118);
    chk("col3_row", 32'(led_row), 32'hFE);
    chk("col3_strobe", 32'(led_col), 32'h7);

    // 3: back-buffer write without swap stays invisible
    goto(120);
    write_col(2'd2, 8'h81);
    goto(129);
    chk("fs_f2", 32'(frame_start), 32'h1);
    chk("no_swap_f2", 32'(swap_done), 32'h0);
    goto(166);
    chk("hidden_write_f2", 32'(led_row), 32'h00);
    goto(230);
    chk("hidden_write_f3", 32'(led_row), 32'h00);
    goto(294);
    chk("hidden_write_f4", 32'(led_row), 32'h00);

    // 4: swap_req and write in the boundary cycle
    goto(319);
    swap_req = 1'b1;
    wr_en    = 1'b1;
    wr_col   = 2'd1;
    wr_data  = 8'h77;
    step(1);
    swap_req = 1'b0;
    wr_en    = 1'b0;
    step(1);
    chk("swap_done_boundary", 32'(swap_done), 32'h1);
    chk("fs_f5", 32'(frame_start), 32'h1);
    goto(326);
    chk("f5_col0", 32'(led_row), 32'hFF);

    // 5: mid-frame brightness change takes effect next frame
    goto(330);
    brightness = 2'd0;
    goto(342);
    chk("f5_col1_boundary_write", 32'(led_row), 32'h88);
    goto(358);
    chk("f5_col2_bright_held", 32'(led_row), 32'h7E);
    goto(402);
    chk("f6_col1_slot1_dark", 32'(led_row), 32'hFF);
    goto(406);
    chk("f6_col1_slot5_dark", 32'(led_row), 32'hFF);
    goto(428);
    chk("f6_col2_slot11_dark", 32'(led_row), 32'hFF);

    // 6: pending swap dropped by mid-frame reset; buffers cleared
    goto(440);
    brightness = 2'd3;
    goto(450);
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
    goto(460);
    reset = 1'b1;
    step(2);
    chk("rst2_led_col", 32'(led_col), 32'hF);
    chk("rst2_led_row", 32'(led_row), 32'hFF);
    reset = 1'b0;
    k     = 0;
    step(1);
    chk("rst2_fs", 32'(frame_start), 32'h1);
    chk("rst2_no_swap", 32'(swap_done), 32'h0);
    chk("rst2_col0", 32'(led_col), 32'hE);
    goto(65);
    chk("rst2_fs_f1", 32'(frame_start), 32'h1);
    chk("rst2_dropped_swap", 32'(swap_done), 32'h0);
    goto(70);
    chk("rst2_col0_cleared", 32'(led_row), 32'hFF);
    goto(86);
    chk("rst2_col1_cleared", 32'(led_row), 32'hFF);
    goto(102);
    chk("rst2_col2_cleared", 32'(led_row), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
